// File: rtl/fsm4_ctx_sched_if.sv
// fsm4_ctx_sched_if: request/grant and per-channel status bundle for the
// multi-context A/B/C/D scheduler.
//   req_val  [NCH]      channel i has an input bit pending
//   req_data [NCH]      input bit for channel i
//   req_rdy  [NCH]      one-hot grant (or all zero)
//   clr      [NCH]      synchronous per-channel clear
//   ch_state [2*NCH]    channel i state at [2i+1:2i] (A=0 B=1 C=2 D=3)
//   ch_out0  [NCH]      Moore out0 per channel
//   ch_out1  [NCH]      Moore out1 per channel
//   d_count  [CW*NCH]   channel i D-entry count at [CW*i+CW-1:CW*i]
// master = producer/consumer side, slave = scheduler side.
interface fsm4_ctx_sched_if #(
  parameter int NCH = 4,
  parameter int CW  = 8
);
  logic [NCH-1:0]    req_val;
  logic [NCH-1:0]    req_data;
  logic [NCH-1:0]    req_rdy;
  logic [NCH-1:0]    clr;
  logic [2*NCH-1:0]  ch_state;
  logic [NCH-1:0]    ch_out0;
  logic [NCH-1:0]    ch_out1;
  logic [CW*NCH-1:0] d_count;

  modport master (
    output req_val, req_data, clr,
    input  req_rdy, ch_state, ch_out0, ch_out1, d_count
  );

  modport slave (
    input  req_val, req_data, clr,
    output req_rdy, ch_state, ch_out0, ch_out1, d_count
  );
endinterface

// File: rtl/fsm4_ctx_sched.sv
// fsm4_ctx_sched: keeps one 2-bit A/B/C/D Moore state per channel and shares a
// single next-state evaluator among NCH requesters with round-robin grants.
// Also counts (saturating) entries into state D per channel.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      fsm4_ctx_sched_if slave modport (requests, grants, status)
module fsm4_ctx_sched #(
  parameter int NCH = 4,
  parameter int CW  = 8
) (
  input logic              clk,
  input logic              reset_n,
  fsm4_ctx_sched_if.slave  bus
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] ST_A = 2'd0;
  localparam logic [1:0] ST_B = 2'd1;
  localparam logic [1:0] ST_C = 2'd2;
  localparam logic [1:0] ST_D = 2'd3;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [PW:0]   NCH_W   = (PW+1)'(NCH);

  // Shared next-state evaluator for the A/B/C/D machine.
  function automatic logic [1:0] next_state(input logic [1:0] s, input logic b);
    logic [1:0] n;
    case (s)
      ST_A:    n = b ? ST_B : ST_A;
      ST_B:    n = b ? ST_B : ST_C;
      ST_C:    n = b ? ST_D : ST_A;
      ST_D:    n = b ? ST_B : ST_C;
      default: n = ST_A;
    endcase
    return n;
  endfunction

  logic [1:0]    state_q [NCH];
  logic [1:0]    state_d [NCH];
  logic [CW-1:0] cnt_q   [NCH];
  logic [CW-1:0] cnt_d   [NCH];
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  logic [NCH-1:0] elig_s;
  logic [NCH-1:0] grant_s;
  logic [PW-1:0]  gidx_s;
  logic           gany_s;

  // A cleared channel is never eligible, so clear and grant never collide.
  assign elig_s      = bus.req_val & ~bus.clr;
  assign bus.req_rdy = grant_s;

  // Round-robin scan starting at ptr, wrapping mod NCH.
  always_comb begin
    logic [PW:0] sum_v;
    logic [PW-1:0] idx_v;
    grant_s = '0;
    gidx_s  = '0;
    gany_s  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      sum_v = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum_v >= NCH_W) begin
        sum_v = sum_v - NCH_W;
      end else begin
      end
      idx_v = sum_v[PW-1:0];
      if (!gany_s && elig_s[idx_v]) begin
        grant_s[idx_v] = 1'b1;
        gidx_s         = idx_v;
        gany_s         = 1'b1;
      end else begin
      end
    end
  end

  // Pointer moves to the channel after the winner; holds when nothing is granted.
  always_comb begin
    logic [PW:0] nxt_v;
    nxt_v = {1'b0, gidx_s} + {{PW{1'b0}}, 1'b1};
    if (nxt_v >= NCH_W) begin
      nxt_v = '0;
    end else begin
    end
    if (gany_s) begin
      ptr_d = nxt_v[PW-1:0];
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Per-channel next state and saturating D-entry counter.
  always_comb begin
    logic [1:0] ns_v;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      ns_v       = next_state(state_q[i], bus.req_data[i]);
      if (bus.clr[i]) begin
        state_d[i] = ST_A;
        cnt_d[i]   = '0;
      end else if (grant_s[i]) begin
        state_d[i] = ns_v;
        if ((ns_v == ST_D) && (state_q[i] != ST_D) && (cnt_q[i] != CNT_MAX)) begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end else begin
        state_d[i] = state_q[i];
        cnt_d[i]   = cnt_q[i];
      end
    end
  end

  // State, counter and pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_A;
        cnt_q[i]   <= '0;
      end
      ptr_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      ptr_q <= ptr_d;
    end
  end

  // Moore decode {out0,out1}: A=00, B=01, C=01, D=10.
  always_comb begin
    bus.ch_state = '0;
    bus.ch_out0  = '0;
    bus.ch_out1  = '0;
    bus.d_count  = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.ch_state[2*i +: 2] = state_q[i];
      bus.ch_out0[i]         = (state_q[i] == ST_D);
      bus.ch_out1[i]         = (state_q[i] == ST_B) || (state_q[i] == ST_C);
      bus.d_count[CW*i +: CW] = cnt_q[i];
    end
  end

endmodule
